// File: rtl/vdma_axi_pkg.sv
// Shared AXI constants and the AW-channel state encoding for the VDMA write engine.
// Build option: VDMA_4K_BOUNDARY_EN enables 4KB boundary splitting.
package vdma_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned AXI_4KB       = 4096;

    typedef enum logic [1:0] {
        AW_IDLE,
        AW_CALC,
        AW_ADDR,
        AW_WAIT
    } aw_state_t;

endpackage

// File: rtl/vdma_len_fifo.sv
// Burst-length FIFO between the AW issue side and the W data side.
module vdma_len_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [8:0] push_len,
    input  logic       pop,
    output logic [8:0] pop_len,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_len = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_len;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vdma_axi_wr_engine.sv
// VDMA AXI4 write master: splits a beat-count request into INCR bursts.
// Build option: VDMA_4K_BOUNDARY_EN keeps every burst inside one 4KB page.
module vdma_axi_wr_engine
    import vdma_axi_pkg::*;
#(
    parameter int M_AXI_ID_WIDTH      = 4,
    parameter int M_AXI_ID            = 0,
    parameter int M_AXI_ADDR_WIDTH    = 28,
    parameter int M_AXI_DATA_WIDTH    = 256,
    parameter int M_AXI_MAX_BURST_LEN = 16,
    parameter int MAX_OUTSTANDING     = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic [M_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [15:0]                   req_size,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [M_AXI_DATA_WIDTH-1:0]   src_data,
    input  logic                          src_avail,
    output logic                          src_pop,
    output logic                          done,
    output logic                          err,
    input  logic                          err_clr,
    output logic [M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int AW  = M_AXI_ADDR_WIDTH;
    localparam int SZ  = $clog2(M_AXI_DATA_WIDTH / 8);
    localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;

    aw_state_t      state;
    logic [AW-1:0]  addr_q;
    logic [15:0]    left_q;
    logic [8:0]     blen_q;
    logic [8:0]     blen;
    logic [OCW-1:0] outstanding;
    logic [OCW-1:0] out_nxt;
    logic           aw_hs;
    logic           w_hs;
    logic           b_hs;
    logic           w_active;
    logic [8:0]     w_left;
    logic           fifo_pop;
    logic [8:0]     fifo_len;
    logic           fifo_full;
    logic           fifo_empty;
    logic           unused_bits;

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;

    assign M_AXI_AWID    = M_AXI_ID_WIDTH'(M_AXI_ID);
    assign M_AXI_AWSIZE  = 3'(SZ);
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_WDATA   = src_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = w_active && src_avail;
    assign M_AXI_WLAST   = w_active && (w_left == 9'd1);
    assign src_pop       = w_hs;
    assign unused_bits   = ^{M_AXI_BID, fifo_full};

    always_comb begin
        out_nxt = outstanding;
        if (aw_hs && !b_hs) out_nxt = outstanding + OCW'(1);
        else if (!aw_hs && b_hs) out_nxt = outstanding - OCW'(1);
    end

    always_comb begin
        blen = (left_q > 16'(M_AXI_MAX_BURST_LEN)) ?
               9'(M_AXI_MAX_BURST_LEN) : left_q[8:0];
`ifdef VDMA_4K_BOUNDARY_EN
        begin
            logic [12:0] to_4k;
            to_4k = 13'(AXI_4KB) - {1'b0, addr_q[11:0]};
            if ((to_4k >> SZ) < 13'(blen)) blen = 9'(to_4k >> SZ);
        end
`endif
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= AW_IDLE;
            req_ready     <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= '0;
            addr_q        <= '0;
            left_q        <= '0;
            blen_q        <= '0;
            outstanding   <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            M_AXI_BREADY <= 1'b1;
            outstanding  <= out_nxt;
            done         <= 1'b0;
            // a new error wins over a same-cycle clear
            if (b_hs && M_AXI_BRESP != AXI_RESP_OKAY) err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            unique case (state)
                AW_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        addr_q <= req_addr;
                        left_q <= req_size;
                        if (req_size == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            req_ready <= 1'b0;
                            state     <= AW_CALC;
                        end
                    end
                end
                AW_CALC: begin
                    if (outstanding != OCW'(MAX_OUTSTANDING)) begin
                        blen_q        <= blen;
                        M_AXI_AWADDR  <= addr_q;
                        M_AXI_AWLEN   <= 8'(blen - 9'd1);
                        M_AXI_AWVALID <= 1'b1;
                        state         <= AW_ADDR;
                    end
                end
                AW_ADDR: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        addr_q <= addr_q + (AW'(blen_q) << SZ);
                        left_q <= left_q - 16'(blen_q);
                        state  <= (left_q == 16'(blen_q)) ? AW_WAIT : AW_CALC;
                    end
                end
                AW_WAIT: begin
                    if (out_nxt == '0) begin
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= AW_IDLE;
                    end
                end
                default: state <= AW_IDLE;
            endcase
        end
    end

    assign fifo_pop = !w_active && !fifo_empty;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            w_active <= 1'b0;
            w_left   <= '0;
        end else if (!w_active) begin
            if (!fifo_empty) begin
                w_active <= 1'b1;
                w_left   <= fifo_len;
            end
        end else if (w_hs) begin
            w_left <= w_left - 9'd1;
            if (w_left == 9'd1) w_active <= 1'b0;
        end
    end

    vdma_len_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_len_fifo (
        .clk      (M_AXI_ACLK),
        .rst_n    (M_AXI_ARESETN),
        .push     (aw_hs),
        .push_len (blen_q),
        .pop      (fifo_pop),
        .pop_len  (fifo_len),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_vdma_axi_wr_engine.sv
// Directed bench for vdma_axi_wr_engine with a small AXI write slave model.
// Expectations follow VDMA_4K_BOUNDARY_EN when it is defined.
module tb_vdma_axi_wr_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [27:0]  req_addr = '0;
    logic [15:0]  req_size = '0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [255:0] src_data = '0;
    logic         src_avail = 1'b0;
    logic         src_pop;
    logic         done;
    logic         err;
    logic         err_clr = 1'b0;
    logic [3:0]   awid;
    logic [27:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready = 1'b0;
    logic [3:0]   bid = '0;
    logic [1:0]   bresp = '0;
    logic         bvalid = 1'b0;
    logic         bready;

    vdma_axi_wr_engine #(
        .M_AXI_ID_WIDTH      (4),
        .M_AXI_ID            (0),
        .M_AXI_ADDR_WIDTH    (28),
        .M_AXI_DATA_WIDTH    (256),
        .M_AXI_MAX_BURST_LEN (16),
        .MAX_OUTSTANDING     (2)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .src_data      (src_data),
        .src_avail     (src_avail),
        .src_pop       (src_pop),
        .done          (done),
        .err           (err),
        .err_clr       (err_clr),
        .M_AXI_AWID    (awid),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWLEN   (awlen),
        .M_AXI_AWSIZE  (awsize),
        .M_AXI_AWBURST (awburst),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WLAST   (wlast),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BID     (bid),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready)
    );

    always #5 clk = ~clk;

    // knobs owned by the main sequence
    logic aw_rdy_en = 1'b1;
    logic b_hold = 1'b0;
    int   err_idx = -1;

    // slave / monitor state, written only by the monitor
    int          cyc = 0;
    int          w_beats = 0;
    int          issued_beats = 0;
    int          n_wlast = 0;
    int          n_b = 0;
    int          n_done = 0;
    int          stab_err = 0;
    int          over_err = 0;
    int          data_err = 0;
    int          pop_err = 0;
    int          strb_err = 0;
    logic        aw_wait = 1'b0;
    logic [27:0] aw_prev_addr = '0;
    logic [7:0]  aw_prev_len = '0;
    int          aw_addr_q[$];
    int          aw_len_q[$];
    int          wlast_at[$];

    always @(negedge clk) begin
        cyc++;
        awready   = aw_rdy_en;
        wready    = 1'b1;
        src_avail = (cyc % 5) != 3;
        src_data  = {8{32'(w_beats)}};
        bvalid    = !b_hold && (n_wlast > n_b);
        bresp     = (n_b == err_idx) ? 2'b10 : 2'b00;
        #1;
        if (!rst_n) begin
            n_b          = n_wlast;
            issued_beats = w_beats;
            aw_wait      = 1'b0;
        end else begin
            if (aw_wait && (!awvalid || awaddr != aw_prev_addr ||
                            awlen != aw_prev_len))
                stab_err++;
            aw_wait      = awvalid && !awready;
            aw_prev_addr = awaddr;
            aw_prev_len  = awlen;
            if (awvalid && awready) begin
                aw_addr_q.push_back(int'(awaddr));
                aw_len_q.push_back(int'(awlen));
                issued_beats += int'(awlen) + 1;
            end
            if (src_pop != (wvalid && wready)) pop_err++;
            if (wdata != src_data) data_err++;
            if (wstrb != '1) strb_err++;
            if (wvalid && wready) begin
                w_beats++;
                if (w_beats > issued_beats) over_err++;
                if (wlast) begin
                    wlast_at.push_back(w_beats);
                    n_wlast++;
                end
            end
            if (bvalid && bready) n_b++;
            if (done) n_done++;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int base_aw, base_beats, base_wl, base_done;

    task automatic mark();
        base_aw    = aw_addr_q.size();
        base_beats = w_beats;
        base_wl    = wlast_at.size();
        base_done  = n_done;
    endtask

    task automatic do_req(input logic [27:0] a, input logic [15:0] s);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("req_rdy_wait", t < 100, 1);
        req_addr  = a;
        req_size  = s;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (n_done == base_done && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_wait", t < budget, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_aw(input string tag, input int idx,
                            input int a, input int l);
        check({tag, "_addr"}, aw_addr_q[base_aw + idx], a);
        check({tag, "_len"}, aw_len_q[base_aw + idx], l);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_bready", bready, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);
        check("awsize", awsize, 5);
        check("awburst", awburst, 1);
        check("awid", awid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", req_ready, 0);
        @(negedge clk);
        #2;
        check("rdy_after_edge", req_ready, 1);
        check("bready_after_edge", bready, 1);

        // 64 beats from 0: four full bursts
        mark();
        do_req(28'h0, 16'd64);
        wait_done(1000);
        check("a_naw", aw_addr_q.size() - base_aw, 4);
        for (int i = 0; i < 4; i++) check_aw("a_aw", i, i * 'h200, 15);
        check("a_beats", w_beats - base_beats, 64);
        check("a_ndone", n_done - base_done, 1);
        check("a_err", err, 0);

        // 20 beats: 16 + 4
        mark();
        do_req(28'h2000, 16'd20);
        wait_done(600);
        check("b_naw", aw_addr_q.size() - base_aw, 2);
        check_aw("b_aw0", 0, 'h2000, 15);
        check_aw("b_aw1", 1, 'h2200, 3);
        check("b_nlast", wlast_at.size() - base_wl, 2);
        check("b_last0", wlast_at[base_wl] - base_beats, 16);
        check("b_last1", wlast_at[base_wl + 1] - base_beats, 20);

        // 4KB page crossing
        mark();
        do_req(28'hF80, 16'd16);
        wait_done(600);
`ifdef VDMA_4K_BOUNDARY_EN
        check("c_naw", aw_addr_q.size() - base_aw, 2);
        check_aw("c_aw0", 0, 'hF80, 3);
        check_aw("c_aw1", 1, 'h1000, 11);
`else
        check("c_naw", aw_addr_q.size() - base_aw, 1);
        check_aw("c_aw0", 0, 'hF80, 15);
`endif
        check("c_beats", w_beats - base_beats, 16);

        // zero-length request
        mark();
        do_req(28'h100, 16'd0);
        #2;
        check("z_done_hi", done, 1);
        @(negedge clk);
        #2;
        check("z_done_lo", done, 0);
        check("z_naw", aw_addr_q.size() - base_aw, 0);
        check("z_ndone", n_done - base_done, 1);

        // AW backpressure, B withheld, two outstanding max
        mark();
        aw_rdy_en = 1'b0;
        b_hold    = 1'b1;
        do_req(28'h0, 16'd64);
        repeat (10) @(negedge clk);
        #2;
        check("e_awvalid_held", awvalid, 1);
        check("e_naw_stall", aw_addr_q.size() - base_aw, 0);
        check("e_no_w", w_beats - base_beats, 0);
        aw_rdy_en = 1'b1;
        repeat (80) @(negedge clk);
        check("e_naw_cap", aw_addr_q.size() - base_aw, 2);
        check("e_beats_cap", w_beats - base_beats, 32);
        b_hold = 1'b0;
        wait_done(1000);
        check("e_naw", aw_addr_q.size() - base_aw, 4);
        check("e_beats", w_beats - base_beats, 64);

        // SLVERR on the second burst
        mark();
        err_idx = n_b + 1;
        do_req(28'h0, 16'd64);
        wait_done(1000);
        err_idx = -1;
        check("f_err", err, 1);
        check("f_naw", aw_addr_q.size() - base_aw, 4);
        check("f_beats", w_beats - base_beats, 64);
        check("f_ndone", n_done - base_done, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #2;
        check("f_err_clr", err, 0);

        // reset in the middle of a transfer
        mark();
        do_req(28'h0, 16'd64);
        begin
            int t = 0;
            while ((w_beats - base_beats) < 5 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("g_midwait", t < 200, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("g_awvalid", awvalid, 0);
        check("g_wvalid", wvalid, 0);
        check("g_wlast", wlast, 0);
        check("g_bready", bready, 0);
        check("g_req_ready", req_ready, 0);
        check("g_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("g_no_done", n_done - base_done, 0);
        mark();
        do_req(28'h4000, 16'd20);
        wait_done(600);
        check("g_naw", aw_addr_q.size() - base_aw, 2);
        check_aw("g_aw0", 0, 'h4000, 15);
        check("g_beats", w_beats - base_beats, 20);
        check("g_ndone", n_done - base_done, 1);

        check("stab_err", stab_err, 0);
        check("over_err", over_err, 0);
        check("data_err", data_err, 0);
        check("pop_err", pop_err, 0);
        check("strb_err", strb_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
